shift_sequencer: RTL

- Initiator side of the shift-unit interface. Accepts one shift request at a time from the controller/decode stage.
- Presents operand, function and count to the combinational-result shifter, then produces a clean low-to-high transition on shift_enable.
- After a programmable settle window, captures the result and carry, computes Z, and issues a one-cycle register-file/flag writeback.
- Carries an internal expected-value model and flags any mismatch with the shifter's answer.

---
 rtl/shift_sequencer_pkg.sv | 20 ++
 rtl/shift_sequencer_expect.sv | 43 ++++
 rtl/shift_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: function codes, data width and FSM states.
package shift_sequencer_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] SHL_FN = 2'b00;
  localparam logic [1:0] SHR_FN = 2'b01;
  localparam logic [1:0] ROL_FN = 2'b10;
  localparam logic [1:0] ROR_FN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_FIRE    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_WB      = 3'd5
  } seq_state_e;

endpackage

// File: rtl/shift_sequencer_expect.sv
// Combinational expected-value model of the shifter: result and carry for (fn, count, data).
module shift_expect
  import shift_sequencer_pkg::*;
(
  input  logic [1:0]        fn_i,
  input  logic [2:0]        count_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] exp_result_o,
  output logic              exp_c_o
);

  logic [DATA_W:0]   shl_w;
  logic [DATA_W:0]   shr_w;
  logic [3:0]        back_amt;
  logic [DATA_W-1:0] rol_w;
  logic [DATA_W-1:0] ror_w;

  // The extra bit beside the operand catches the last bit shifted out; it stays 0 for count 0.
  assign shl_w    = {1'b0, data_i} << count_i;
  assign shr_w    = {data_i, 1'b0} >> count_i;
  assign back_amt = 4'd8 - {1'b0, count_i};
  assign rol_w    = (data_i << count_i) | (data_i >> back_amt);
  assign ror_w    = (data_i >> count_i) | (data_i << back_amt);

  always_comb begin
    exp_result_o = data_i;
    exp_c_o      = 1'b0;
    case (fn_i)
      SHL_FN: begin
        exp_result_o = shl_w[DATA_W-1:0];
        exp_c_o      = shl_w[DATA_W];
      end
      SHR_FN: begin
        exp_result_o = shr_w[DATA_W:1];
        exp_c_o      = shr_w[0];
      end
      ROL_FN:  exp_result_o = rol_w;
      ROR_FN:  exp_result_o = ror_w;
      default: exp_result_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Initiator for the combinational shift unit: sets up operands, fires shift_enable,
// waits a settle window, captures the answer and issues a one-cycle writeback.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int DST_W         = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_fn,
  input  logic [2:0]        req_count,
  input  logic [DATA_W-1:0] req_data,
  input  logic [DST_W-1:0]  req_dst,
  output logic [DATA_W-1:0] shift_data,
  output logic [1:0]        shift_opcode,
  output logic [2:0]        shift_count,
  output logic              shift_enable,
  input  logic [DATA_W-1:0] shift_result,
  input  logic              shift_c,
  output logic              wb_en,
  output logic [DST_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_we,
  output logic              flag_z,
  output logic              flag_c,
  output logic              busy,
  output logic              chk_err
);

  localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);

  seq_state_e        state_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] shift_data_q;
  logic [1:0]        shift_opcode_q;
  logic [2:0]        shift_count_q;
  logic              shift_enable_q;
  logic [DST_W-1:0]  dst_q;
  logic              wb_en_q;
  logic [DST_W-1:0]  wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              flag_we_q;
  logic              flag_z_q;
  logic              flag_c_q;
  logic              chk_err_q;

  logic [DATA_W-1:0] exp_result;
  logic              exp_c;
  logic              chk_err_d;

  // The operand registers driving the shifter double as the latched request.
  shift_expect u_expect (
    .fn_i         (shift_opcode_q),
    .count_i      (shift_count_q),
    .data_i       (shift_data_q),
    .exp_result_o (exp_result),
    .exp_c_o      (exp_c)
  );

  assign chk_err_d = (shift_result != exp_result) || (shift_c != exp_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      shift_data_q   <= '0;
      shift_opcode_q <= '0;
      shift_count_q  <= '0;
      shift_enable_q <= 1'b0;
      dst_q          <= '0;
      wb_en_q        <= 1'b0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
      flag_we_q      <= 1'b0;
      flag_z_q       <= 1'b0;
      flag_c_q       <= 1'b0;
      chk_err_q      <= 1'b0;
    end else begin
      wb_en_q   <= 1'b0;
      flag_we_q <= 1'b0;
      chk_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            shift_data_q   <= req_data;
            shift_opcode_q <= req_fn;
            shift_count_q  <= req_count;
            dst_q          <= req_dst;
            state_q        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          shift_enable_q <= 1'b1;
          cnt_q          <= SETTLE_LOAD;
          state_q        <= ST_FIRE;
        end
        // FIRE counts as the first settle cycle, so SETTLE lasts SETTLE_CYCLES-1 cycles.
        ST_FIRE, ST_SETTLE: begin
          if (cnt_q == 3'd0) begin
            state_q <= ST_CAPTURE;
          end else begin
            cnt_q   <= cnt_q - 3'd1;
            state_q <= ST_SETTLE;
          end
        end
        ST_CAPTURE: begin
          shift_enable_q <= 1'b0;
          wb_en_q        <= 1'b1;
          flag_we_q      <= 1'b1;
          wb_addr_q      <= dst_q;
          wb_data_q      <= shift_result;
          flag_z_q       <= (shift_result == '0);
          flag_c_q       <= shift_c;
          chk_err_q      <= chk_err_d;
          state_q        <= ST_WB;
        end
        ST_WB: begin
          shift_data_q   <= '0;
          shift_opcode_q <= '0;
          shift_count_q  <= '0;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = ~req_ready;
  assign shift_data   = shift_data_q;
  assign shift_opcode = shift_opcode_q;
  assign shift_count  = shift_count_q;
  assign shift_enable = shift_enable_q;
  assign wb_en        = wb_en_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign flag_we      = flag_we_q;
  assign flag_z       = flag_z_q;
  assign flag_c       = flag_c_q;
  assign chk_err      = chk_err_q;

endmodule
